xmt_fifo: RTL
=============

// Module: xmt_fifo
// PURPOSE
//  UART transmit-side buffer: the mirror of the receive FIFO.
//  On a start pulse, fetches msg_len bytes from message memory, one read command per byte.
//  Buffers the bytes in a DEPTH-entry FIFO and presents the head byte to the UART transmitter.
//  Sits between message memory (read side) and the transmit serializer (pop side).
// PARAMETERS
//  DATA_W  8  byte width; must match memory and transmitter
//  DEPTH   8  FIFO entries; power of two, >=2
//  LEN_W   8  width of message length and memory byte address
//  (derived localparam ADDR_W = $clog2(DEPTH))
// PORTS
//  clk           in   1         single clock; all state on posedge
//  rst           in   1         asynchronous, active-high reset
//  start         in   1         1-cycle pulse: begin fetching a message; ignored while busy
//  msg_len       in   LEN_W     bytes to fetch; sampled on accepted start
//  mem_rd_cmd    out  1         registered 1-cycle read request, one per byte
//  mem_rd_addr   out  LEN_W     byte offset 0..msg_len-1; valid with mem_rd_cmd
//  mem_rd_data   in   DATA_W    memory data, valid exactly 1 cycle after mem_rd_cmd
//  rd_xmt_fifo   in   1         transmitter pops head byte; ignored when empty
//  xmt_data      out  DATA_W    head byte, first-word-fall-through; stable while !empty
//  full          out  1         count == DEPTH
//  empty         out  1         count == 0
//  busy          out  1         fetch in progress (FETCH or DRAIN)
//  done          out  1         1-cycle pulse when last byte has been written into FIFO
// BEHAVIOUR
//  Reset: state IDLE; wr_ptr/rd_ptr/count/issued = 0; mem_rd_cmd=0, mem_rd_addr=0,
//    busy=0, done=0, empty=1, full=0, xmt_data=0. Storage contents not reset.
//  FSM IDLE->FETCH: start && msg_len!=0. start with msg_len==0: stay IDLE, pulse done next cycle.
//  FETCH: issue mem_rd_cmd when count + inflight < DEPTH (credit rule).
//    inflight = 1 if mem_rd_cmd was asserted last cycle, else 0.
//    The credit rule makes FIFO overflow impossible. mem_rd_addr = issued; issued increments per command.
//  FETCH->DRAIN: in the cycle the command with issued==msg_len-1 is issued.
//  DRAIN->IDLE: in the cycle the final byte is written. done pulses that cycle (registered, visible next cycle).
//  Write: wr_en = mem_rd_cmd delayed 1 cycle.
//    mem[wr_ptr] <= mem_rd_data; wr_ptr increments mod DEPTH (natural ADDR_W wrap).
//  Pop: rd_xmt_fifo && !empty -> rd_ptr increments mod DEPTH. Pop on empty: no effect.
//  count: +1 on write only; -1 on pop only; unchanged on simultaneous write+pop.
//  Write into empty FIFO: xmt_data valid and empty=0 the cycle after the write edge.
//  full/empty are derived from count (width ADDR_W+1), never from pointers alone.
//  start while busy: ignored, no state change.
//  Pops continue in any FSM state. FIFO is not flushed between messages.
//  Reset mid-fetch: all in-flight data discarded; returns to reset state immediately.
// CONFIGURATION
//  XMT_FIFO_LEVEL_EN defined: adds output level [ADDR_W:0] = count (registered), and
//    sticky output pop_underflow, set on rd_xmt_fifo while empty, cleared only by rst.
//  Undefined: neither port exists; pops on empty are silently ignored.
// STRUCTURE
//  uart_pkg: DATA_W constant; typedef enum logic [1:0] {XF_IDLE, XF_FETCH, XF_DRAIN} xmt_fetch_state_t.
//  Sub-module xmt_fifo_mem: DEPTH x DATA_W storage with pointers and count.
//    Interface: push/pop/din/dout/count.
//  Top level holds the fetch FSM, credit logic and address counter.
// TESTING
//  1. start, msg_len=3, no pops -> mem_rd_cmd at addr 0,1,2 on consecutive cycles;
//     count=3; done pulses once; busy=0.
//  2. msg_len=12, DEPTH=8, no pops -> exactly 8 commands, then stall with full=1;
//     pop 4 -> 4 more commands; done after byte 11.
//  3. Continuous pop while fetching msg_len=20 -> bytes leave in order 0..19 across pointer wrap;
//     no loss or duplication.
//  4. Simultaneous write+pop at count=1 -> count stays 1; xmt_data advances to next byte.
//  5. Pop on empty (and start with msg_len=0) -> pointers unchanged; empty=1;
//     done pulses; with XMT_FIFO_LEVEL_EN, pop_underflow=1.
//  6. rst asserted mid-fetch with 2 in flight -> all outputs at reset values;
//     next start fetches from addr 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmit-side types: byte width and the fetch FSM state encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    XF_IDLE  = 2'd0,
    XF_FETCH = 2'd1,
    XF_DRAIN = 2'd2
  } xmt_fetch_state_t;

endpackage

// File: rtl/xmt_fifo_if.sv
// Memory read bus plus transmitter pop/head-byte signals of xmt_fifo.
// Optional XMT_FIFO_LEVEL_EN adds level and pop_underflow.
interface xmt_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              mem_rd_cmd;
  logic [LEN_W-1:0]  mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              rd_xmt_fifo;
  logic [DATA_W-1:0] xmt_data;
  logic              full;
  logic              empty;
`ifdef XMT_FIFO_LEVEL_EN
  logic [ADDR_W:0]   level;
  logic              pop_underflow;

  modport master (
    output mem_rd_cmd, mem_rd_addr, xmt_data, full, empty, level, pop_underflow,
    input  mem_rd_data, rd_xmt_fifo
  );
  modport slave (
    input  mem_rd_cmd, mem_rd_addr, xmt_data, full, empty, level, pop_underflow,
    output mem_rd_data, rd_xmt_fifo
  );
`else
  modport master (
    output mem_rd_cmd, mem_rd_addr, xmt_data, full, empty,
    input  mem_rd_data, rd_xmt_fifo
  );
  modport slave (
    input  mem_rd_cmd, mem_rd_addr, xmt_data, full, empty,
    output mem_rd_data, rd_xmt_fifo
  );
`endif
endinterface

// File: rtl/xmt_fifo_mem.sv
// DEPTH x DATA_W first-word-fall-through FIFO storage with pointers and occupancy count.
// Head byte is a registered read of the array, with a bypass when a write lands on the new head.
module xmt_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_array [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_next;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic [DATA_W-1:0] dout_reg;
  logic              pop_ok;

  assign pop_ok = pop && (count_reg != '0);

  always_comb begin
    rd_ptr_next = rd_ptr_reg + ADDR_W'(pop_ok);
    count_next  = count_reg;
    if (push && !pop_ok) begin
      count_next = count_reg + 1'b1;
    end else if (!push && pop_ok) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_array[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      // Hold the head while empty; forward din when the write becomes the new head.
      if (count_next != '0) begin
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
          dout_reg <= din;
        end else begin
          dout_reg <= mem_array[rd_ptr_next];
        end
      end
    end
  end

  assign dout  = dout_reg;
  assign count = count_reg;

endmodule

// File: rtl/xmt_fifo.sv
// UART transmit buffer: fetches msg_len bytes from message memory into a FWFT FIFO.
// Define XMT_FIFO_LEVEL_EN to expose level and sticky pop_underflow.
module xmt_fifo #(
  parameter int DATA_W = uart_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  output logic             busy,
  output logic             done,
  xmt_fifo_if.master       bus
);
  import uart_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  xmt_fetch_state_t  state_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  issued_reg;
  logic [LEN_W-1:0]  wr_cnt_reg;
  logic              cmd_reg;
  logic [LEN_W-1:0]  addr_reg;
  logic              wr_en_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [ADDR_W:0]   count;
  logic [ADDR_W+1:0] committed;
  logic              credit_ok;
  logic              last_issue;
  logic              last_write;

  // Both the command on the bus and the byte about to be written are owed FIFO slots.
  assign committed  = {1'b0, count} + (ADDR_W+2)'(cmd_reg) + (ADDR_W+2)'(wr_en_reg);
  assign credit_ok  = committed < (ADDR_W+2)'(DEPTH);
  assign last_issue = (issued_reg == len_reg - LEN_W'(1));
  assign last_write = wr_en_reg && (wr_cnt_reg == len_reg - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= XF_IDLE;
      len_reg    <= '0;
      issued_reg <= '0;
      wr_cnt_reg <= '0;
      cmd_reg    <= 1'b0;
      addr_reg   <= '0;
      wr_en_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      cmd_reg   <= 1'b0;
      wr_en_reg <= cmd_reg;
      if (wr_en_reg) begin
        wr_cnt_reg <= wr_cnt_reg + 1'b1;
      end
      case (state_reg)
        XF_IDLE: begin
          if (start) begin
            if (msg_len != '0) begin
              state_reg  <= XF_FETCH;
              busy_reg   <= 1'b1;
              len_reg    <= msg_len;
              issued_reg <= '0;
              wr_cnt_reg <= '0;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        XF_FETCH: begin
          if (credit_ok) begin
            cmd_reg    <= 1'b1;
            addr_reg   <= issued_reg;
            issued_reg <= issued_reg + 1'b1;
            if (last_issue) begin
              state_reg <= XF_DRAIN;
            end
          end
        end
        XF_DRAIN: begin
          if (last_write) begin
            state_reg <= XF_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= XF_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  xmt_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en_reg),
    .pop   (bus.rd_xmt_fifo),
    .din   (bus.mem_rd_data),
    .dout  (bus.xmt_data),
    .count (count)
  );

  assign bus.mem_rd_cmd  = cmd_reg;
  assign bus.mem_rd_addr = addr_reg;
  assign bus.full        = (count == (ADDR_W+1)'(DEPTH));
  assign bus.empty       = (count == '0);
  assign busy            = busy_reg;
  assign done            = done_reg;

`ifdef XMT_FIFO_LEVEL_EN
  logic underflow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_reg <= 1'b0;
    end else if (bus.rd_xmt_fifo && (count == '0)) begin
      underflow_reg <= 1'b1;
    end
  end

  assign bus.level         = count;
  assign bus.pop_underflow = underflow_reg;
`endif

endmodule
